// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle control sequencer for the 8-bit, 4-register CPU datapath.
// Adds run/single-step control, a retired-instruction counter and a memory-timeout fault.
module cpu_seq_ctrl #(
   parameter int TIMEOUT   = 15,
   parameter bit START_RUN = 1'b1
) (
   input  logic       clk50,
   input  logic       reset,
   input  logic       run,
   input  logic       step,
   input  logic [7:0] instr,
   input  logic       mem_ready,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_src,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       alu_src,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem_to_reg,
   output logic [2:0] state,
   output logic [7:0] retired,
   output logic       fault,
   output logic       busy
);

   // state  | meaning
   // IDLE   | stopped at an instruction boundary, waiting for run or step
   // FETCH  | load IR, PC <= PC+1, latch opcode
   // DECODE | jumps complete here; others continue to EXEC
   // EXEC   | ALU operation / address calculation
   // MEM    | data memory access, waits for mem_ready with timeout
   // WB     | register file write-back, instruction retires
   // FAULT  | memory timeout or illegal state; held until reset

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_FAULT  = 3'd7
   } state_t;

   localparam state_t     RESET_STATE = START_RUN ? S_FETCH : S_IDLE;
   localparam logic [1:0] OP_ADD      = 2'b00;
   localparam logic [1:0] OP_LW       = 2'b01;
   localparam logic [1:0] OP_SW       = 2'b10;
   localparam logic [1:0] OP_J        = 2'b11;
   localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT - 1);

   state_t     cur;
   state_t     boundary;
   logic [1:0] op;
   logic [7:0] wait_cnt;
   logic       unused_instr;

   assign unused_instr = ^instr[5:0];
   assign state        = cur;
   assign boundary     = run ? S_FETCH : S_IDLE;

   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         cur      <= RESET_STATE;
         op       <= 2'b00;
         wait_cnt <= 8'd0;
         retired  <= 8'd0;
         fault    <= 1'b0;
      end else begin
         case (cur)
            S_IDLE: begin
               if (run || step)
                  cur <= S_FETCH;
            end
            S_FETCH: begin
               op  <= instr[7:6];
               cur <= S_DECODE;
            end
            S_DECODE: begin
               if (op == OP_J) begin
                  retired <= retired + 8'd1;
                  cur     <= boundary;
               end else begin
                  cur <= S_EXEC;
               end
            end
            S_EXEC: begin
               wait_cnt <= 8'd0;
               cur      <= (op == OP_ADD) ? S_WB : S_MEM;
            end
            S_MEM: begin
               // a ready on the last allowed cycle still wins over the timeout
               if (mem_ready) begin
                  wait_cnt <= 8'd0;
                  if (op == OP_SW) begin
                     retired <= retired + 8'd1;
                     cur     <= boundary;
                  end else begin
                     cur <= S_WB;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
                  if (wait_cnt == TMO_LAST) begin
                     cur   <= S_FAULT;
                     fault <= 1'b1;
                  end
               end
            end
            S_WB: begin
               retired <= retired + 8'd1;
               cur     <= boundary;
            end
            S_FAULT: begin
               fault <= 1'b1;
            end
            default: begin
               cur   <= S_FAULT;
               fault <= 1'b1;
            end
         endcase
      end
   end

   // Moore decode; gated by reset so enables drop the moment reset asserts
   always_comb begin
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      alu_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      busy       = 1'b0;
      if (reset) begin
         busy = (cur != S_IDLE) && (cur != S_FAULT);
         case (cur)
            S_FETCH: begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
            S_DECODE: begin
               if (op == OP_J) begin
                  pc_write = 1'b1;
                  pc_src   = 1'b1;
               end
            end
            S_EXEC: begin
               alu_src = (op != OP_ADD);
            end
            S_MEM: begin
               alu_src   = 1'b1;
               mem_read  = (op == OP_LW);
               mem_write = (op == OP_SW);
            end
            S_WB: begin
               reg_write = 1'b1;
               if (op == OP_ADD)
                  reg_dst = 1'b1;
               else
                  mem_to_reg = 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Scoreboard bench for cpu_seq_ctrl: per-instruction reference model pushes the expected
// per-cycle outputs; a monitor pops and compares every cycle on the falling edge.
module tb_cpu_seq_ctrl;
   localparam int TMO = 15;

   localparam logic [2:0] SI = 3'd0, SF = 3'd1, SD = 3'd2, SE = 3'd3, SM = 3'd4, SW = 3'd5, SX = 3'd7;
   localparam logic [8:0] Z9   = 9'h000;
   localparam logic [8:0] IRW  = 9'h100, PCW = 9'h080, PCS = 9'h040, RGW = 9'h020, RDST = 9'h010;
   localparam logic [8:0] ALU  = 9'h008, MRD = 9'h004, MWR = 9'h002, MTR = 9'h001;

   logic       clk50 = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0;
   logic       step = 1'b0;
   logic       mem_ready = 1'b0;
   logic [7:0] instr = 8'h00;
   logic       ir_write, pc_write, pc_src, reg_write, reg_dst, alu_src;
   logic       mem_read, mem_write, mem_to_reg, fault, busy;
   logic [2:0] state;
   logic [7:0] retired;

   cpu_seq_ctrl #(.TIMEOUT(TMO), .START_RUN(1'b1)) dut (
      .clk50(clk50), .reset(reset), .run(run), .step(step), .instr(instr),
      .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src), .mem_read(mem_read),
      .mem_write(mem_write), .mem_to_reg(mem_to_reg), .state(state), .retired(retired),
      .fault(fault), .busy(busy)
   );

   always #10 clk50 = ~clk50;

   int         total = 0;
   int         bad = 0;
   logic [21:0] sb[$];
   logic [7:0] m_ret = 8'd0;
   logic       m_fault = 1'b0;
   bit         in_idle = 1'b0;

   wire [8:0]  ctl_act = {ir_write, pc_write, pc_src, reg_write, reg_dst, alu_src,
                          mem_read, mem_write, mem_to_reg};
   wire [21:0] act = {state, busy, ctl_act, fault, retired};

   task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, a, e);
      end
   endtask

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [7:0] rnd8();
      return 8'($urandom);
   endfunction

   function automatic logic [21:0] mk(input logic [2:0] st, input logic [8:0] ctl);
      logic b;
      b = (st != SI) && (st != SX);
      return {st, b, ctl, m_fault, m_ret};
   endfunction

   initial begin
      forever begin
         @(negedge clk50);
         if (sb.size() > 0) begin
            logic [21:0] e;
            e = sb.pop_front();
            check($sformatf("cycle@%0t", $time), 32'(act), 32'(e));
         end
      end
   end

   task automatic do_cycle(input logic [2:0] st, input logic [8:0] ctl, input logic rn,
                           input logic stp, input logic mr, input logic [7:0] ins);
      run = rn;
      step = stp;
      mem_ready = mr;
      instr = ins;
      sb.push_back(mk(st, ctl));
      @(posedge clk50);
      #1;
   endtask

   // one instruction from the boundary; w = wait cycles before mem_ready, w >= TMO never answers
   task automatic run_instr(input logic [1:0] op, input int w, input bit r);
      logic [8:0] mctl;
      if (in_idle) begin
         int k;
         logic go;
         k = $urandom_range(0, 3);
         for (int i = 0; i < k; i++)
            do_cycle(SI, Z9, 1'b0, 1'b0, rnd1(), rnd8());
         go = rnd1();
         do_cycle(SI, Z9, go, ~go, rnd1(), rnd8());
      end
      do_cycle(SF, IRW | PCW, rnd1(), rnd1(), rnd1(), {op, 6'($urandom)});
      if (op == 2'b11) begin
         do_cycle(SD, PCW | PCS, r, rnd1(), rnd1(), rnd8());
         m_ret++;
         in_idle = !r;
         return;
      end
      do_cycle(SD, Z9, rnd1(), rnd1(), rnd1(), rnd8());
      do_cycle(SE, (op == 2'b00) ? Z9 : ALU, rnd1(), rnd1(), rnd1(), rnd8());
      if (op == 2'b00) begin
         do_cycle(SW, RGW | RDST, r, rnd1(), rnd1(), rnd8());
         m_ret++;
         in_idle = !r;
         return;
      end
      mctl = ALU | ((op == 2'b01) ? MRD : MWR);
      if (w >= TMO) begin
         for (int i = 0; i < TMO; i++)
            do_cycle(SM, mctl, rnd1(), rnd1(), 1'b0, rnd8());
         m_fault = 1'b1;
         for (int i = 0; i < 5; i++)
            do_cycle(SX, Z9, rnd1(), rnd1(), rnd1(), rnd8());
         return;
      end
      for (int i = 0; i < w; i++)
         do_cycle(SM, mctl, rnd1(), rnd1(), 1'b0, rnd8());
      if (op == 2'b10) begin
         do_cycle(SM, mctl, r, rnd1(), 1'b1, rnd8());
         m_ret++;
      end else begin
         do_cycle(SM, mctl, rnd1(), rnd1(), 1'b1, rnd8());
         do_cycle(SW, RGW | MTR, r, rnd1(), rnd1(), rnd8());
         m_ret++;
      end
      in_idle = !r;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      run = 1'b1;
      instr = 8'h00;
      repeat (3) @(posedge clk50);
      #1;
      check("rst_state", 32'(state), 32'd1);
      check("rst_ctl", 32'({ctl_act, busy}), 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
      reset = 1'b1;
      in_idle = 1'b0;

      for (int i = 0; i < 3; i++)
         run_instr(2'b00, 0, 1'b1);
      check("retired_3add", 32'(retired), 32'd3);
      run_instr(2'b01, 3, 1'b1);
      run_instr(2'b10, 0, 1'b1);
      run_instr(2'b11, 0, 1'b1);
      run_instr(2'b01, 2, 1'b0);
      check("idle_state", 32'({state, busy}), 32'd0);
      run_instr(2'b00, 0, 1'b0);
      check("step_idle", 32'(state), 32'd0);
      run_instr(2'b10, TMO - 1, 1'b1);
      run_instr(2'b01, TMO - 1, 1'b1);

      for (int n = 0; n < 150; n++) begin
         logic [1:0] op;
         int w;
         bit r;
         op = 2'($urandom);
         w = ($urandom_range(0, 7) == 0) ? TMO - 1 : $urandom_range(0, 4);
         r = ($urandom_range(0, 3) != 0);
         run_instr(op, w, r);
      end

      run_instr(2'b00, 0, 1'b1);
      do_cycle(SF, IRW | PCW, 1'b1, 1'b0, 1'b0, {2'b01, 6'($urandom)});
      do_cycle(SD, Z9, 1'b1, 1'b0, 1'b0, rnd8());
      do_cycle(SE, ALU, 1'b1, 1'b0, 1'b0, rnd8());
      mem_ready = 1'b0;
      sb.push_back(mk(SM, ALU | MRD));
      @(negedge clk50);
      #3;
      reset = 1'b0;
      #1;
      check("async_ctl", 32'({ctl_act, busy}), 32'd0);
      check("async_state", 32'(state), 32'd1);
      check("async_retired", 32'(retired), 32'd0);
      m_ret = 8'd0;
      m_fault = 1'b0;
      in_idle = 1'b0;
      @(posedge clk50);
      #1;
      reset = 1'b1;

      for (int i = 0; i < 256; i++)
         run_instr(2'b11, 0, 1'b1);
      check("retired_wrap", 32'(retired), 32'd0);

      run_instr(2'b10, TMO, 1'b1);
      check("fault_flag", 32'({state, fault}), 32'({3'd7, 1'b1}));
      check("fault_ctl", 32'({ctl_act, busy}), 32'd0);
      #5;
      reset = 1'b0;
      #1;
      check("fault_cleared", 32'({state, fault}), 32'({3'd1, 1'b0}));

      for (int i = 0; i < 10 && sb.size() > 0; i++)
         @(negedge clk50);
      if (sb.size() > 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the team's 8-bit, 4-register CPU datapath (8-bit instruction {op[7:6], rs[5:4], rt[3:2], imm/rd[1:0]}; op 00=add, 01=lw, 10=sw, 11=j).
- Steps the datapath through FETCH/DECODE/EXEC/MEM/WB, drives all datapath enables and muxes, and handshakes with data memory.
- Adds run/single-step control, a retired-instruction counter and a memory-timeout fault, used for board debug on the seven-segment display.

Parameters:
- TIMEOUT, 15, max cycles waiting for mem_ready in MEM before FAULT (1..255).
- START_RUN, 1, if 1 the block leaves reset in run mode, else in IDLE.

Ports:
- clk50  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = free-run, 0 = stop at next instruction boundary
- step  in  1  single-cycle pulse; executes one instruction while in IDLE
- instr  in  8  instruction word from instruction memory at current PC
- mem_ready  in  1  data memory done (read data valid / write accepted)
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC
- pc_src  out  1  0 = PC+1, 1 = jump target (PC+1+sext(imm))
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 = write rt (lw), 1 = write imm field as rd (add)
- alu_src  out  1  0 = rt register, 1 = sext(imm)
- mem_read  out  1  data memory read request
- mem_write  out  1  data memory write request
- mem_to_reg  out  1  1 = write-back data from memory
- state  out  3  current state encoding, for display
- retired  out  8  instructions completed, wraps 255->0
- fault  out  1  sticky memory-timeout flag
- busy  out  1  1 when not in IDLE or FAULT

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, FAULT=7. state is the registered encoding.
- Reset (reset=0, async): state=FETCH if START_RUN=1 else IDLE; ir latch=0; retired=0; fault=0; timeout counter=0. All control outputs are 0 while reset is held.
- Control outputs are Moore: decoded combinationally from state plus the latched opcode only, never from instr directly.
- FETCH: ir_write=1, pc_write=1, pc_src=0; opcode latched. Next state DECODE.
- DECODE: if op=11, pc_write=1, pc_src=1, retire, then go to the boundary. Otherwise go to EXEC. No other outputs.
- EXEC: alu_src = 1 for lw/sw, 0 for add. add->WB, lw/sw->MEM.
- MEM: mem_read=1 (lw) or mem_write=1 (sw), held until mem_ready=1; alu_src stays 1.
  - On mem_ready: lw->WB; sw retires and goes to the boundary.
  - Counter increments each waiting cycle. Sampling mem_ready=1 on the same cycle the counter reaches TIMEOUT counts as success.
  - Reaching TIMEOUT without mem_ready: go to FAULT and set fault=1.
  - mem_ready outside MEM is ignored.
- WB: reg_write=1. add: reg_dst=1, mem_to_reg=0. lw: reg_dst=0, mem_to_reg=1. Retire, then go to the boundary.
- Latency (mem_ready in the first MEM cycle): add=4 cycles, lw=5, sw=4, j=2. Each extra wait cycle adds 1.
- Boundary: go to FETCH if run=1, else IDLE. run is sampled only here; deasserting run mid-instruction never aborts it.
- IDLE: go to FETCH if run=1 or step=1. A step pulse runs exactly one instruction, then returns to IDLE (run=0). step outside IDLE is ignored.
- Retire: retired increments by 1 on the cycle the instruction's final state exits; modulo 256.
- FAULT: all enables 0, busy=0, fault=1. Stays there until reset; run/step are ignored.
- Undefined encodings 6 are unreachable. If reached, go to FAULT.

Test Plan:
- Reset with START_RUN=1, run=1, program add/add/...: ir_write pulses every 4 cycles; reg_write=1 with reg_dst=1 in each WB; retired=3 after 12 cycles from first FETCH.
- lw with mem_ready delayed 3 cycles: MEM held 4 cycles with mem_read=1; WB has mem_to_reg=1, reg_dst=0; total 8 cycles; retired +1.
- sw, then j: sw asserts mem_write only, no reg_write; j takes 2 cycles with pc_write=1, pc_src=1 in DECODE.
- run=0 asserted mid-lw: lw completes, block enters IDLE (state=0, busy=0). A step pulse executes exactly one instruction (retired +1) and returns to IDLE.
- mem_ready never asserted on sw, TIMEOUT=15: FAULT entered after 15 MEM cycles, fault=1, mem_write drops to 0. run/step are then ignored; reset clears fault.
- Async reset asserted in MEM: outputs go to 0 immediately, not at the clock edge; retired=0, state returns to the reset state. Retired wrap: 256 j instructions -> retired=0.
